// File: rtl/pwm_multichannel.sv
// Multi-channel PWM generator with one shared period counter.
//
// A single counter runs either edge-aligned (0..P, wrap) or centre-aligned
// (0..P..1, repeat). Each channel compares the counter against its own duty value.
// Period, duty and mode are double-buffered. A load strobe writes the shadow copy,
// and the shadow moves into the active copy only at a period boundary, so outputs
// never glitch mid-period. While disabled, the active copy follows the shadow
// continuously.
//
// Ports:
//   clk            in   clock, all logic on the rising edge
//   rst            in   asynchronous reset, active-high
//   enable         in   1 = counter runs; 0 = counter held at 0 and outputs low
//   load           in   strobe: capture period_in/duty_in/centre_in into the shadow
//   centre_in      in   0 = edge-aligned, 1 = centre-aligned (shadowed)
//   period_in      in   period value P (shadowed)
//   duty_in        in   packed duty values, channel i at [i*WIDTH +: WIDTH] (shadowed)
//   pwm            out  registered PWM outputs, one per channel
//   period_end     out  one-cycle pulse in the first cycle of each new period
//   update_pending out  shadow holds values not yet applied
//   count          out  current counter value
module pwm_multichannel #(
  parameter int unsigned WIDTH    = 10,
  parameter int unsigned CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      load,
  input  logic                      centre_in,
  input  logic [WIDTH-1:0]          period_in,
  input  logic [CHANNELS*WIDTH-1:0] duty_in,
  output logic [CHANNELS-1:0]       pwm,
  output logic                      period_end,
  output logic                      update_pending,
  output logic [WIDTH-1:0]          count
);

  typedef enum logic {
    DirUp,
    DirDown
  } dir_e;

  dir_e dir_q, dir_d;

  logic [WIDTH-1:0]                count_q, count_d;
  logic [WIDTH-1:0]                per_act_q, per_act_d;
  logic [WIDTH-1:0]                per_sh_q, per_sh_d;
  logic [CHANNELS-1:0][WIDTH-1:0]  duty_act_q, duty_act_d;
  logic [CHANNELS-1:0][WIDTH-1:0]  duty_sh_q, duty_sh_d;
  logic                            centre_act_q, centre_act_d;
  logic                            centre_sh_q, centre_sh_d;
  logic [CHANNELS-1:0]             pwm_q, pwm_d;
  logic                            pe_q, pe_d;
  logic                            pend_q, pend_d;

  logic centre_eff;
  logic boundary;

  // Centre counting needs P >= 2; below that the up/down sequence degenerates,
  // so the counter falls back to edge behaviour.
  assign centre_eff = centre_act_q && (|per_act_q[WIDTH-1:1]);

  // Last cycle of a period: top of the ramp in edge mode, count 1 on the way
  // down in centre mode.
  assign boundary = centre_eff ? ((count_q == WIDTH'(1)) && (dir_q == DirDown))
                               : (count_q == per_act_q);

  always_comb begin
    count_d      = count_q;
    dir_d        = dir_q;
    per_act_d    = per_act_q;
    per_sh_d     = per_sh_q;
    duty_act_d   = duty_act_q;
    duty_sh_d    = duty_sh_q;
    centre_act_d = centre_act_q;
    centre_sh_d  = centre_sh_q;
    pwm_d        = '0;
    pe_d         = 1'b0;
    pend_d       = pend_q;

    if (load) begin
      per_sh_d    = period_in;
      centre_sh_d = centre_in;
      for (int i = 0; i < CHANNELS; i++) begin
        duty_sh_d[i] = duty_in[i*WIDTH +: WIDTH];
      end
    end

    if (!enable) begin
      count_d      = '0;
      dir_d        = DirUp;
      // Take the freshly loaded values straight through so nothing is left
      // pending once the cycle after a load is reached.
      per_act_d    = per_sh_d;
      duty_act_d   = duty_sh_d;
      centre_act_d = centre_sh_d;
      pend_d       = 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        pwm_d[i] = (count_q < duty_act_q[i]);
      end
      pe_d = boundary;

      if (boundary) begin
        count_d      = '0;
        dir_d        = DirUp;
        // Apply the shadow as it stood before this cycle; a load landing on the
        // boundary waits for the next one.
        per_act_d    = per_sh_q;
        duty_act_d   = duty_sh_q;
        centre_act_d = centre_sh_q;
        pend_d       = load;
      end else begin
        pend_d = pend_q | load;
        if (!centre_eff) begin
          count_d = count_q + WIDTH'(1);
        end else if (dir_q == DirUp) begin
          if (count_q == per_act_q) begin
            count_d = count_q - WIDTH'(1);
            dir_d   = DirDown;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q      <= '0;
      dir_q        <= DirUp;
      per_act_q    <= '1;
      per_sh_q     <= '1;
      duty_act_q   <= '0;
      duty_sh_q    <= '0;
      centre_act_q <= 1'b0;
      centre_sh_q  <= 1'b0;
      pwm_q        <= '0;
      pe_q         <= 1'b0;
      pend_q       <= 1'b0;
    end else begin
      count_q      <= count_d;
      dir_q        <= dir_d;
      per_act_q    <= per_act_d;
      per_sh_q     <= per_sh_d;
      duty_act_q   <= duty_act_d;
      duty_sh_q    <= duty_sh_d;
      centre_act_q <= centre_act_d;
      centre_sh_q  <= centre_sh_d;
      pwm_q        <= pwm_d;
      pe_q         <= pe_d;
      pend_q       <= pend_d;
    end
  end

  assign pwm            = pwm_q;
  assign period_end     = pe_q;
  assign update_pending = pend_q;
  assign count          = count_q;

endmodule

// File: tb/tb_pwm_multichannel.sv
// Scoreboard bench for pwm_multichannel. Each expected period (length, per-channel
// high count, peak count, pending flag at the period_end pulse) is queued by the
// stimulus; the monitor measures the DUT between period_end pulses and pops one
// record per pulse.
module tb_pwm_multichannel;

  localparam int W = 10;
  localparam int C = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic             load;
  logic             centre_in;
  logic [W-1:0]     period_in;
  logic [C*W-1:0]   duty_in;
  logic [C-1:0]     pwm;
  logic             period_end;
  logic             update_pending;
  logic [W-1:0]     count;

  always #5 clk = ~clk;

  pwm_multichannel #(
    .WIDTH    (W),
    .CHANNELS (C)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .load           (load),
    .centre_in      (centre_in),
    .period_in      (period_in),
    .duty_in        (duty_in),
    .pwm            (pwm),
    .period_end     (period_end),
    .update_pending (update_pending),
    .count          (count)
  );

  typedef struct packed {
    int len;
    int h0;
    int h1;
    int h2;
    int h3;
    int maxc;
    int pend;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push(input int len, input int h0, input int h1, input int h2,
                      input int h3, input int maxc, input int pend);
    exp_t e;
    e.len  = len;
    e.h0   = h0;
    e.h1   = h1;
    e.h2   = h2;
    e.h3   = h3;
    e.maxc = maxc;
    e.pend = pend;
    exp_q.push_back(e);
  endtask

  // Monitor: accumulate over (previous period_end, this period_end].
  initial begin
    int   m_len;
    int   m_hi[C];
    int   m_max;
    int   rec_n;
    logic prev_en;
    exp_t e;
    m_len   = 0;
    m_max   = 0;
    rec_n   = 0;
    prev_en = 1'b0;
    for (int i = 0; i < C; i++) m_hi[i] = 0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        prev_en = 1'b0;
        m_len   = 0;
        m_max   = 0;
        for (int i = 0; i < C; i++) m_hi[i] = 0;
      end else begin
        if (prev_en) begin
          m_len++;
          for (int i = 0; i < C; i++) m_hi[i] += int'(pwm[i]);
          if (int'(count) > m_max) m_max = int'(count);
          if (period_end) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_period_end", 1, 0);
            end else begin
              e = exp_q.pop_front();
              rec_n++;
              chk($sformatf("p%0d_len", rec_n), m_len, e.len);
              chk($sformatf("p%0d_high0", rec_n), m_hi[0], e.h0);
              chk($sformatf("p%0d_high1", rec_n), m_hi[1], e.h1);
              chk($sformatf("p%0d_high2", rec_n), m_hi[2], e.h2);
              chk($sformatf("p%0d_high3", rec_n), m_hi[3], e.h3);
              chk($sformatf("p%0d_maxcount", rec_n), m_max, e.maxc);
              chk($sformatf("p%0d_pending", rec_n), int'(update_pending), e.pend);
              chk($sformatf("p%0d_count_at_end", rec_n), int'(count), 0);
            end
            m_len = 0;
            m_max = 0;
            for (int i = 0; i < C; i++) m_hi[i] = 0;
          end
        end else begin
          m_len = 0;
          m_max = 0;
          for (int i = 0; i < C; i++) m_hi[i] = 0;
        end
        prev_en = enable;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pe(input string name);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!period_end && n < 3000);
    if (!period_end) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic wait_count(input int v, input string name);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (int'(count) != v && n < 3000);
    if (int'(count) != v) chk({name, "_timeout"}, int'(count), v);
  endtask

  // Inputs are set now, captured at the next edge; returns #1 after that edge.
  task automatic drive_load(input int p, input int c, input int d0, input int d1,
                            input int d2, input int d3);
    period_in = W'(p);
    centre_in = c[0];
    duty_in   = {W'(d3), W'(d2), W'(d1), W'(d0)};
    load      = 1'b1;
    step();
    load      = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    enable    = 1'b0;
    load      = 1'b0;
    centre_in = 1'b0;
    period_in = '0;
    duty_in   = '0;
    repeat (3) step();
    chk("reset_count", int'(count), 0);
    chk("reset_pwm", int'(pwm), 0);
    chk("reset_period_end", int'(period_end), 0);
    chk("reset_pending", int'(update_pending), 0);
    rst = 1'b0;
    step();

    // 1: load while running from reset values (P=1023, D=0).
    push(1024, 0, 0, 0, 0, 1023, 0);
    push(10, 3, 0, 10, 9, 9, 0);
    enable = 1'b1;
    drive_load(9, 0, 3, 0, 10, 9);
    chk("t1_pending_after_load", int'(update_pending), 1);
    wait_pe("t1_first_boundary");

    // 2: mid-period duty change takes effect from the next period.
    wait_count(4, "t2_count4");
    drive_load(9, 0, 7, 0, 10, 9);
    chk("t2_pending_mid_period", int'(update_pending), 1);
    push(10, 7, 0, 10, 9, 9, 1);
    wait_pe("t2_boundary");

    // 3: load on the boundary cycle is deferred a full period.
    wait_count(9, "t3_count9");
    drive_load(9, 0, 5, 0, 10, 9);
    chk("t3_period_end_after_boundary", int'(period_end), 1);
    chk("t3_pending_after_boundary_load", int'(update_pending), 1);
    push(10, 7, 0, 10, 9, 9, 0);
    wait_count(5, "t3_count5");
    chk("t3_pending_held", int'(update_pending), 1);
    wait_pe("t3_boundary");

    // 4: switch to centre mode, P=8, D0=4 -> 16-cycle period, 7 high.
    push(10, 5, 0, 10, 9, 9, 0);
    push(16, 7, 0, 16, 16, 8, 0);
    push(16, 7, 0, 16, 16, 8, 0);
    wait_count(2, "t4_count2");
    drive_load(8, 1, 4, 0, 10, 9);
    wait_pe("t4_boundary_edge");
    wait_pe("t4_boundary_centre1");
    wait_pe("t4_boundary_centre2");

    // 5: disabled load of P=5 goes straight to active.
    repeat (3) step();
    enable = 1'b0;
    repeat (2) step();
    chk("t5_disabled_pwm", int'(pwm), 0);
    chk("t5_disabled_count", int'(count), 0);
    chk("t5_disabled_period_end", int'(period_end), 0);
    drive_load(5, 0, 3, 0, 10, 9);
    chk("t5_pending_cleared", int'(update_pending), 0);
    chk("t5_count_held", int'(count), 0);
    push(6, 3, 0, 6, 6, 5, 0);
    push(6, 3, 0, 6, 6, 5, 0);
    repeat (2) step();
    enable = 1'b1;
    wait_pe("t5_boundary1");
    wait_count(2, "t5_count2");
    drive_load(9, 0, 3, 0, 10, 9);
    wait_pe("t5_boundary2");

    // 6: reset mid-period at count 6 with an update pending.
    wait_count(2, "t6_count2");
    drive_load(3, 0, 1, 1, 1, 1);
    chk("t6_pending_before_reset", int'(update_pending), 1);
    wait_count(6, "t6_count6");
    #2;
    rst = 1'b1;
    #1;
    chk("t6_reset_count", int'(count), 0);
    chk("t6_reset_pwm", int'(pwm), 0);
    chk("t6_reset_period_end", int'(period_end), 0);
    chk("t6_reset_pending", int'(update_pending), 0);
    push(1024, 0, 0, 0, 0, 1023, 0);
    step();
    rst = 1'b0;
    wait_pe("t6_boundary_after_reset");

    enable = 1'b0;
    repeat (2) step();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
